// File: rtl/z80_bus_tracer.sv
// z80_bus_tracer
//   Observes the raw Z80 bus from the fclk domain. Each completed bus cycle is
//   classified, timestamped and pushed into a first-word-fall-through FIFO that
//   a host drains.
//
// Ports
//   fclk, rst                 system clock, synchronous active-high reset
//   m1_n .. rfsh_n            raw Z80 strobes (active low)
//   a[15:0], d[7:0]           Z80 address / data bus
//   romnram                   current access targets ROM (from z80mem)
//   type_mask[5:0]            per-type capture enable, bit index = type code
//   dedup_en                  drop an opcode fetch equal to the last pushed one
//   trig_en, trig_addr        wait for an opcode fetch at trig_addr before capturing
//   arm, stop                 one-cycle session control pulses
//   rd_ready                  host pop handshake
//   rd_valid, rd_data         FIFO head {type, romnram, a, d, ts}
//   count                     FIFO occupancy (0..DEPTH)
//   dropped                   saturating count of lost entries
//   state                     0 IDLE, 1 ARMED, 2 CAPTURE, 3 STOPPED
module z80_bus_tracer #(
    parameter int DEPTH        = 64,
    parameter int TS_W         = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int STOP_ON_FULL = 0,
    parameter int DROP_W       = 8
) (
    input  logic                     fclk,
    input  logic                     rst,
    input  logic                     m1_n,
    input  logic                     mreq_n,
    input  logic                     iorq_n,
    input  logic                     rd_n,
    input  logic                     wr_n,
    input  logic                     rfsh_n,
    input  logic [15:0]              a,
    input  logic [7:0]               d,
    input  logic                     romnram,
    input  logic [5:0]               type_mask,
    input  logic                     dedup_en,
    input  logic                     trig_en,
    input  logic [15:0]              trig_addr,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [27+TS_W:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DROP_W-1:0]        dropped,
    output logic [1:0]               state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int EW    = 28 + TS_W;
    localparam int SW    = 31;
    // Strobes idle high, everything else zero.
    localparam logic [SW-1:0] SYNC_RST = {6'b111111, 25'd0};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_STOPPED = 2'd3
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------ synchronizer
    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic [SW-1:0] sync_d [SYNC_STAGES];
    logic [SW-1:0] sync_out;

    always_comb begin
        sync_d[0] = {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, romnram, a, d};
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge fclk) begin
        for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            if (rst) sync_q[i] <= SYNC_RST;
            else     sync_q[i] <= sync_d[i];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    logic        s_m1, s_mreq, s_iorq, s_rd, s_wr, s_rfsh, s_rom;
    logic [15:0] s_a;
    logic [7:0]  s_d;

    assign s_m1   = ~sync_out[30];
    assign s_mreq = ~sync_out[29];
    assign s_iorq = ~sync_out[28];
    assign s_rd   = ~sync_out[27];
    assign s_wr   = ~sync_out[26];
    assign s_rfsh = ~sync_out[25];
    assign s_rom  = sync_out[24];
    assign s_a    = sync_out[23:8];
    assign s_d    = sync_out[7:0];

    // --------------------------------------------------------- classification
    logic       cls_vld;
    logic [2:0] cls_type;

    always_comb begin
        cls_vld  = 1'b0;
        cls_type = 3'd0;
        if (!s_rfsh) begin
            if (s_m1 && s_iorq)                 begin cls_vld = 1'b1; cls_type = 3'd5; end
            else if (s_m1 && s_mreq && s_rd)    begin cls_vld = 1'b1; cls_type = 3'd0; end
            else if (s_mreq && s_rd)            begin cls_vld = 1'b1; cls_type = 3'd1; end
            else if (s_mreq && s_wr)            begin cls_vld = 1'b1; cls_type = 3'd2; end
            else if (s_iorq && s_rd)            begin cls_vld = 1'b1; cls_type = 3'd3; end
            else if (s_iorq && s_wr)            begin cls_vld = 1'b1; cls_type = 3'd4; end
        end
    end

    // Previous-fclk snapshot of the bus; it holds the last active values when
    // a cycle ends.
    logic        cur_vld_q, cur_vld_d;
    logic [2:0]  cur_type_q, cur_type_d;
    logic        cur_rom_q, cur_rom_d;
    logic [15:0] cur_a_q, cur_a_d;
    logic [7:0]  cur_d_q, cur_d_d;
    logic        complete;

    always_comb begin
        cur_vld_d  = cls_vld;
        cur_type_d = cls_type;
        cur_rom_d  = s_rom;
        cur_a_d    = s_a;
        cur_d_d    = s_d;
        // A class change with no idle gap ends the old cycle as well.
        complete   = cur_vld_q && (!cls_vld || (cls_type != cur_type_q));
    end

    // Completed-cycle event, one fclk after detection.
    logic            ev_vld_q, ev_vld_d;
    logic [2:0]      ev_type_q, ev_type_d;
    logic            ev_rom_q, ev_rom_d;
    logic [15:0]     ev_a_q, ev_a_d;
    logic [7:0]      ev_d_q, ev_d_d;
    logic [TS_W-1:0] ev_ts_q, ev_ts_d;
    logic [TS_W-1:0] ts_q, ts_d;

    always_comb begin
        ev_vld_d  = complete;
        ev_type_d = cur_type_q;
        ev_rom_d  = cur_rom_q;
        ev_a_d    = cur_a_q;
        ev_d_d    = cur_d_q;
        ev_ts_d   = ts_q;
    end

    // ---------------------------------------------------------- control logic
    logic              dd_vld_q, dd_vld_d;
    logic [15:0]       dd_a_q, dd_a_d;
    logic [7:0]        dd_d_q, dd_d_d;
    logic [DROP_W-1:0] dropped_q, dropped_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [EW-1:0]     mem_q [DEPTH];

    logic       arm_eff, trig_hit, dup, push_req, push, pop, drop, full;
    logic [7:0] mask_ext;

    // Datapath decisions feeding both the FSM and the FIFO.
    always_comb begin
        arm_eff  = arm && !stop;
        mask_ext = {2'b00, type_mask};
        full     = (count_q == CNT_W'(DEPTH));
        pop      = (count_q != '0) && rd_ready;
        trig_hit = (state_q == S_ARMED) && ev_vld_q && (ev_type_q == 3'd0)
                   && (ev_a_q == trig_addr);
        dup      = dedup_en && dd_vld_q && (ev_type_q == 3'd0)
                   && (ev_a_q == dd_a_q) && (ev_d_q == dd_d_q);
        // The triggering fetch is itself logged.
        push_req = ev_vld_q && ((state_q == S_CAPTURE) || (trig_hit && !stop))
                   && mask_ext[ev_type_q] && !dup;
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = (state_q == S_CAPTURE) ? S_STOPPED : S_IDLE;
        end else if (arm) begin
            state_d = trig_en ? S_ARMED : S_CAPTURE;
        end else begin
            case (state_q)
                S_ARMED:   if (trig_hit) state_d = S_CAPTURE;
                S_CAPTURE: if ((STOP_ON_FULL != 0) && drop) state_d = S_STOPPED;
                default:   state_d = state_q;
            endcase
        end
    end

    // FSM: state register
    always_ff @(posedge fclk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: outputs
    always_comb begin
        state    = state_q;
        rd_valid = (count_q != '0);
        rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
        count    = count_q;
        dropped  = dropped_q;
    end

    always_comb begin
        ts_d = ts_q + TS_W'(1);
        if (((state_q == S_IDLE) || (state_q == S_ARMED)) && (state_d == S_CAPTURE)) begin
            ts_d = '0;
        end

        dd_vld_d = dd_vld_q;
        dd_a_d   = dd_a_q;
        dd_d_d   = dd_d_q;
        if (arm_eff) begin
            dd_vld_d = 1'b0;
            dd_a_d   = '0;
            dd_d_d   = '0;
        end else if (push && (ev_type_q == 3'd0)) begin
            dd_vld_d = 1'b1;
            dd_a_d   = ev_a_q;
            dd_d_d   = ev_d_q;
        end

        dropped_d = dropped_q;
        if (arm_eff)                        dropped_d = '0;
        else if (drop && (dropped_q != '1)) dropped_d = dropped_q + DROP_W'(1);

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            cur_vld_q  <= 1'b0;
            cur_type_q <= '0;
            cur_rom_q  <= 1'b0;
            cur_a_q    <= '0;
            cur_d_q    <= '0;
            ev_vld_q   <= 1'b0;
            ev_type_q  <= '0;
            ev_rom_q   <= 1'b0;
            ev_a_q     <= '0;
            ev_d_q     <= '0;
            ev_ts_q    <= '0;
            ts_q       <= '0;
            dd_vld_q   <= 1'b0;
            dd_a_q     <= '0;
            dd_d_q     <= '0;
            dropped_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            cur_vld_q  <= cur_vld_d;
            cur_type_q <= cur_type_d;
            cur_rom_q  <= cur_rom_d;
            cur_a_q    <= cur_a_d;
            cur_d_q    <= cur_d_d;
            ev_vld_q   <= ev_vld_d;
            ev_type_q  <= ev_type_d;
            ev_rom_q   <= ev_rom_d;
            ev_a_q     <= ev_a_d;
            ev_d_q     <= ev_d_d;
            ev_ts_q    <= ev_ts_d;
            ts_q       <= ts_d;
            dd_vld_q   <= dd_vld_d;
            dd_a_q     <= dd_a_d;
            dd_d_q     <= dd_d_d;
            dropped_q  <= dropped_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: rd_data is forced to zero while empty.
    always_ff @(posedge fclk) begin
        if (push) mem_q[wr_ptr_q] <= {ev_type_q, ev_rom_q, ev_a_q, ev_d_q, ev_ts_q};
    end

endmodule

// File: tb/tb_z80_bus_tracer.sv
module tb_z80_bus_tracer;

    localparam int DEPTH  = 4;
    localparam int TS_W   = 16;
    localparam int SYNC   = 2;
    localparam int DROP_W = 8;
    localparam int EW     = 28 + TS_W;

    logic              fclk, rst;
    logic              m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic [15:0]       a;
    logic [7:0]        d;
    logic              romnram;
    logic [5:0]        type_mask;
    logic              dedup_en, trig_en;
    logic [15:0]       trig_addr;
    logic              arm, stop, rd_ready;

    logic              rd_valid, rd_valid_s;
    logic [EW-1:0]     rd_data, rd_data_s;
    logic [$clog2(DEPTH):0] count, count_s;
    logic [DROP_W-1:0] dropped, dropped_s;
    logic [1:0]        state, state_s;

    z80_bus_tracer #(.DEPTH(DEPTH), .TS_W(TS_W), .SYNC_STAGES(SYNC),
                     .STOP_ON_FULL(0), .DROP_W(DROP_W)) u_dut (
        .fclk(fclk), .rst(rst), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .a(a), .d(d), .romnram(romnram),
        .type_mask(type_mask), .dedup_en(dedup_en), .trig_en(trig_en),
        .trig_addr(trig_addr), .arm(arm), .stop(stop), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .count(count), .dropped(dropped),
        .state(state));

    z80_bus_tracer #(.DEPTH(DEPTH), .TS_W(TS_W), .SYNC_STAGES(SYNC),
                     .STOP_ON_FULL(1), .DROP_W(DROP_W)) u_dut_sof (
        .fclk(fclk), .rst(rst), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .a(a), .d(d), .romnram(romnram),
        .type_mask(type_mask), .dedup_en(dedup_en), .trig_en(trig_en),
        .trig_addr(trig_addr), .arm(arm), .stop(stop), .rd_ready(rd_ready),
        .rd_valid(rd_valid_s), .rd_data(rd_data_s), .count(count_s),
        .dropped(dropped_s), .state(state_s));

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------------------------------------------------- reference model
    typedef struct {
        logic [2:0]  t;
        logic        rom;
        logic [15:0] a;
        logic [7:0]  d;
    } ent_t;

    ent_t        q[$];
    int          exp_drop;
    logic        last_vld;
    logic [15:0] last_a;
    logic [7:0]  last_d;

    // Type 6 denotes a refresh cycle, never logged.
    task automatic model_cycle(input logic [2:0] t, input logic [15:0] ad,
                               input logic [7:0] dd, input logic rom);
        ent_t e;
        if (t == 3'd6) return;
        if (!type_mask[t]) return;
        if (dedup_en && t == 3'd0 && last_vld && last_a == ad && last_d == dd) return;
        if (q.size() < DEPTH) begin
            e.t = t; e.rom = rom; e.a = ad; e.d = dd;
            q.push_back(e);
            if (t == 3'd0) begin last_vld = 1'b1; last_a = ad; last_d = dd; end
        end else if (exp_drop < 255) begin
            exp_drop++;
        end
    endtask

    // ---------------------------------------------------------- bus drivers
    task automatic set_idle();
        m1_n = 1; mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; rfsh_n = 1;
        a = '0; d = '0; romnram = 0;
    endtask

    task automatic drive(input logic [2:0] t, input logic [15:0] ad,
                         input logic [7:0] dd, input logic rom);
        set_idle();
        a = ad; d = dd; romnram = rom;
        case (t)
            3'd0: begin m1_n = 0; mreq_n = 0; rd_n = 0; end
            3'd1: begin mreq_n = 0; rd_n = 0; end
            3'd2: begin mreq_n = 0; wr_n = 0; end
            3'd3: begin iorq_n = 0; rd_n = 0; end
            3'd4: begin iorq_n = 0; wr_n = 0; end
            3'd5: begin m1_n = 0; iorq_n = 0; end
            default: begin mreq_n = 0; rd_n = 0; rfsh_n = 0; end
        endcase
    endtask

    task automatic bus(input logic [2:0] t, input logic [15:0] ad,
                       input logic [7:0] dd, input logic rom);
        @(negedge fclk); drive(t, ad, dd, rom);
        repeat (3) @(negedge fclk);
        set_idle();
        repeat (2) @(negedge fclk);
    endtask

    task automatic settle();
        repeat (8) @(negedge fclk);
    endtask

    task automatic pulse_arm();
        @(negedge fclk); arm = 1;
        @(negedge fclk); arm = 0;
    endtask

    task automatic pulse_stop();
        @(negedge fclk); stop = 1;
        @(negedge fclk); stop = 0;
    endtask

    task automatic session_start(input logic [5:0] m, input logic dd, input logic te);
        type_mask = m; dedup_en = dd; trig_en = te;
        q.delete(); exp_drop = 0; last_vld = 0; last_a = '0; last_d = '0;
        pulse_arm();
    endtask

    task automatic session_end();
        pulse_stop();
        pulse_stop();
    endtask

    task automatic pop_one();
        rd_ready = 1;
        @(negedge fclk);
        rd_ready = 0;
    endtask

    task automatic check_head(input string name, input ent_t e);
        logic [EW-1:0] r;
        r = rd_data;
        check({name, " valid"}, 64'(rd_valid), 64'd1);
        check({name, " type"},  64'(r[EW-1 -: 3]), 64'(e.t));
        check({name, " rom"},   64'(r[EW-4]), 64'(e.rom));
        check({name, " addr"},  64'(r[EW-5 -: 16]), 64'(e.a));
        check({name, " data"},  64'(r[TS_W+7 -: 8]), 64'(e.d));
    endtask

    task automatic drain(input string name, input bit chk_ts);
        logic [TS_W-1:0] prev;
        bit first;
        int n;
        first = 1;
        n = q.size();
        check({name, " count"}, 64'(count), 64'(n));
        check({name, " dropped"}, 64'(dropped), 64'(exp_drop));
        for (int i = 0; i < n; i++) begin
            check_head(name, q[0]);
            if (chk_ts && !first) check({name, " ts order"}, 64'(rd_data[TS_W-1:0] > prev), 64'd1);
            prev = rd_data[TS_W-1:0];
            first = 0;
            void'(q.pop_front());
            pop_one();
        end
        check({name, " empty"}, 64'(rd_valid), 64'd0);
    endtask

    // ---------------------------------------------------------- vector table
    typedef struct {
        logic [2:0]  t;
        logic [15:0] a;
        logic [7:0]  d;
        logic        rom;
        logic [5:0]  mask;
        int          exp_n;
        logic [2:0]  exp_t;
    } vec_t;

    vec_t vt[10];

    initial begin
        int lat;
        logic [TS_W-1:0] ts1;
        ent_t e;

        vt[0] = '{3'd0, 16'h1234, 8'hAB, 1'b1, 6'h3F, 1, 3'd0};
        vt[1] = '{3'd1, 16'h8000, 8'h55, 1'b0, 6'h3F, 1, 3'd1};
        vt[2] = '{3'd2, 16'hC000, 8'hAA, 1'b1, 6'h3F, 1, 3'd2};
        vt[3] = '{3'd3, 16'h00FE, 8'h1F, 1'b0, 6'h3F, 1, 3'd3};
        vt[4] = '{3'd4, 16'h00FE, 8'h07, 1'b0, 6'h3F, 1, 3'd4};
        vt[5] = '{3'd5, 16'h0000, 8'hFF, 1'b0, 6'h3F, 1, 3'd5};
        vt[6] = '{3'd6, 16'h0040, 8'h00, 1'b0, 6'h3F, 0, 3'd0};
        vt[7] = '{3'd1, 16'h8000, 8'h55, 1'b0, 6'h3D, 0, 3'd0};
        vt[8] = '{3'd5, 16'h0000, 8'hFF, 1'b0, 6'h1F, 0, 3'd0};
        vt[9] = '{3'd3, 16'h00FF, 8'h33, 1'b1, 6'h08, 1, 3'd3};

        set_idle();
        rst = 1; arm = 0; stop = 0; rd_ready = 0;
        type_mask = 6'h3F; dedup_en = 0; trig_en = 0; trig_addr = '0;
        exp_drop = 0; last_vld = 0; last_a = '0; last_d = '0;
        repeat (3) @(negedge fclk);

        // Reset values
        check("rst state", 64'(state), 64'd0);
        check("rst count", 64'(count), 64'd0);
        check("rst rd_valid", 64'(rd_valid), 64'd0);
        check("rst dropped", 64'(dropped), 64'd0);
        check("rst rd_data", 64'(rd_data), 64'd0);
        rst = 0;
        @(negedge fclk);

        // Basic capture, latency and timestamp order
        session_start(6'h3F, 0, 0);
        check("basic state", 64'(state), 64'd2);
        @(negedge fclk); drive(3'd0, 16'h0000, 8'hF3, 1'b1);
        repeat (3) @(negedge fclk);
        set_idle();
        lat = 0;
        while (lat < 20) begin
            @(negedge fclk);
            lat++;
            if (rd_valid) break;
        end
        check("latency", 64'(lat), 64'(SYNC + 2));
        model_cycle(3'd0, 16'h0000, 8'hF3, 1'b1);
        bus(3'd2, 16'h5B00, 8'h12, 1'b0);
        model_cycle(3'd2, 16'h5B00, 8'h12, 1'b0);
        settle();
        check("basic count2", 64'(count), 64'd2);
        ts1 = rd_data[TS_W-1:0];
        e = q[0]; check_head("basic first", e);
        void'(q.pop_front()); pop_one();
        e = q[0]; check_head("basic second", e);
        check("basic ts increases", 64'(rd_data[TS_W-1:0] > ts1), 64'd1);
        void'(q.pop_front()); pop_one();
        check("basic empty", 64'(count), 64'd0);
        session_end();

        // Table-driven single cycles per type and mask
        foreach (vt[i]) begin
            session_start(vt[i].mask, 0, 0);
            bus(vt[i].t, vt[i].a, vt[i].d, vt[i].rom);
            settle();
            check($sformatf("vec%0d count", i), 64'(count), 64'(vt[i].exp_n));
            if (vt[i].exp_n != 0) begin
                e.t = vt[i].exp_t; e.rom = vt[i].rom; e.a = vt[i].a; e.d = vt[i].d;
                check_head($sformatf("vec%0d", i), e);
                pop_one();
            end
            session_end();
        end

        // Opcode dedup
        session_start(6'h3F, 1, 0);
        repeat (3) begin
            bus(3'd0, 16'h0038, 8'hFF, 1'b1);
            model_cycle(3'd0, 16'h0038, 8'hFF, 1'b1);
        end
        bus(3'd0, 16'h0039, 8'hFF, 1'b1);
        model_cycle(3'd0, 16'h0039, 8'hFF, 1'b1);
        settle();
        check("dedup count", 64'(count), 64'd2);
        drain("dedup", 1);
        session_end();

        // Address trigger
        trig_addr = 16'h0066;
        session_start(6'h3F, 0, 1);
        check("trig armed", 64'(state), 64'd1);
        bus(3'd0, 16'h0000, 8'h00, 1'b1); settle();
        check("trig armed0", 64'(state), 64'd1);
        bus(3'd0, 16'h0001, 8'h01, 1'b1); settle();
        check("trig armed1", 64'(state), 64'd1);
        bus(3'd0, 16'h0066, 8'hED, 1'b1); settle();
        check("trig capture", 64'(state), 64'd2);
        bus(3'd0, 16'h0067, 8'h45, 1'b1); settle();
        e.t = 3'd0; e.rom = 1'b1; e.a = 16'h0066; e.d = 8'hED; q.push_back(e);
        e.a = 16'h0067; e.d = 8'h45; q.push_back(e);
        drain("trig", 0);
        session_end();
        trig_en = 0;

        // Mask with interleaved IO, INTACK and refresh cycles
        session_start(6'b010000, 0, 0);
        bus(3'd4, 16'h00FE, 8'h07, 1'b0); model_cycle(3'd4, 16'h00FE, 8'h07, 1'b0);
        bus(3'd6, 16'h0041, 8'h00, 1'b0); model_cycle(3'd6, 16'h0041, 8'h00, 1'b0);
        bus(3'd3, 16'h00FE, 8'hBF, 1'b0); model_cycle(3'd3, 16'h00FE, 8'hBF, 1'b0);
        bus(3'd6, 16'h0042, 8'h00, 1'b0); model_cycle(3'd6, 16'h0042, 8'h00, 1'b0);
        bus(3'd5, 16'h0000, 8'hFF, 1'b0); model_cycle(3'd5, 16'h0000, 8'hFF, 1'b0);
        settle();
        check("mask count", 64'(count), 64'd1);
        drain("mask", 0);
        session_end();

        // FIFO full: drop vs stop-on-full
        session_start(6'h3F, 0, 0);
        for (int i = 0; i < 5; i++) begin
            bus(3'd1, 16'h4000 + 16'(i), 8'(8'h10 + i), 1'b0);
            model_cycle(3'd1, 16'h4000 + 16'(i), 8'(8'h10 + i), 1'b0);
        end
        settle();
        check("sof state after 5", 64'(state_s), 64'd3);
        check("sof dropped after 5", 64'(dropped_s), 64'd1);
        check("full dropped after 5", 64'(dropped), 64'd1);
        bus(3'd1, 16'h4005, 8'h15, 1'b0);
        model_cycle(3'd1, 16'h4005, 8'h15, 1'b0);
        settle();
        check("full count", 64'(count), 64'd4);
        check("full dropped", 64'(dropped), 64'd2);
        check("full state", 64'(state), 64'd2);
        check("sof dropped after 6", 64'(dropped_s), 64'd1);
        check("sof state after 6", 64'(state_s), 64'd3);

        // Simultaneous push and pop while full
        e = q[0]; check_head("pp head", e);
        @(negedge fclk); drive(3'd1, 16'h4100, 8'h77, 1'b0);
        repeat (3) @(negedge fclk);
        set_idle();
        repeat (3) @(negedge fclk);
        rd_ready = 1;
        @(negedge fclk);
        rd_ready = 0;
        void'(q.pop_front());
        e.t = 3'd1; e.rom = 1'b0; e.a = 16'h4100; e.d = 8'h77; q.push_back(e);
        check("pp count", 64'(count), 64'd4);
        check("pp dropped", 64'(dropped), 64'd2);
        settle();
        drain("pp", 1);
        session_end();

        // Reset in the middle of a capture
        session_start(6'h3F, 0, 0);
        for (int i = 0; i < 3; i++) bus(3'd2, 16'h6000 + 16'(i), 8'(i), 1'b0);
        settle();
        check("midrst count before", 64'(count), 64'd3);
        @(negedge fclk); rst = 1;
        @(negedge fclk); rst = 0;
        check("midrst count", 64'(count), 64'd0);
        check("midrst rd_valid", 64'(rd_valid), 64'd0);
        check("midrst state", 64'(state), 64'd0);
        check("midrst dropped", 64'(dropped), 64'd0);
        q.delete();

        // Randomized sessions against the model
        for (int r = 0; r < 20; r++) begin
            int n;
            logic [2:0]  t;
            logic [15:0] ad;
            logic [7:0]  dd;
            logic        rom;
            session_start(6'($urandom), 1'($urandom), 0);
            n = $urandom_range(1, 7);
            for (int k = 0; k < n; k++) begin
                t   = 3'($urandom_range(0, 6));
                ad  = ($urandom_range(0, 1) == 0) ? 16'h0038 : 16'($urandom);
                dd  = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
                rom = 1'($urandom);
                bus(t, ad, dd, rom);
                model_cycle(t, ad, dd, rom);
            end
            settle();
            check($sformatf("rand%0d state", r), 64'(state), 64'd2);
            drain($sformatf("rand%0d", r), 1);
            session_end();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
